// File: rtl/switch_event_scheduler.sv
// Latches switch release events and serves them one at a time onto LEDs and two 7-segment digits.
// Build option: SWITCH_EVENT_SCHEDULER_FIXED_PRIO_EN selects fixed lowest-index-first arbitration.
module switch_event_scheduler #(
    parameter int unsigned DISPLAY_CYCLES = 25000000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_sw,
    output logic [3:0] o_led,
    output logic [6:0] o_seg1,
    output logic [6:0] o_seg2,
    output logic       o_busy,
    output logic       o_drop
);

    localparam int unsigned CNT_W = (DISPLAY_CYCLES > 1) ? $clog2(DISPLAY_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TIMER_LOAD = CNT_W'(DISPLAY_CYCLES - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        IDLE,
        SHOW
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [3:0]       r_sw_prev;
    logic [3:0]       pending;
    logic [1:0]       last_grant;
    logic [CNT_W-1:0] timer;
    logic [3:0]       count;

    logic [3:0]       sw_rel;
    logic [3:0]       grant_mask;
    logic [3:0]       pending_keep;
    logic [3:0]       pending_next;
    logic             drop_any;
    logic             grant_valid;
    logic [1:0]       grant_idx;
    logic [1:0]       scan_idx;
    logic [3:0]       count_next;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    seg_digit = 7'b1000000;
            4'd1:    seg_digit = 7'b1111001;
            4'd2:    seg_digit = 7'b0100100;
            4'd3:    seg_digit = 7'b0110000;
            4'd4:    seg_digit = 7'b0011001;
            4'd5:    seg_digit = 7'b0010010;
            4'd6:    seg_digit = 7'b0000010;
            4'd7:    seg_digit = 7'b1111000;
            4'd8:    seg_digit = 7'b0000000;
            4'd9:    seg_digit = 7'b0010000;
            default: seg_digit = SEG_BLANK;
        endcase
    endfunction

    // Arbiter scan and FSM next state; a grant is only issued from IDLE.
    always_comb begin
        state_next  = state;
        grant_valid = 1'b0;
        grant_idx   = last_grant;
        scan_idx    = 2'd0;
        for (int i = 0; i < 4; i++) begin
`ifdef SWITCH_EVENT_SCHEDULER_FIXED_PRIO_EN
            scan_idx = 2'(i);
`else
            scan_idx = last_grant + 2'(i + 1);
`endif
            if (state == IDLE && !grant_valid && pending[scan_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx;
            end
        end
        case (state)
            IDLE:    if (grant_valid) state_next = SHOW;
            SHOW:    if (timer == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The grant clears its bit before a same-cycle release re-arms it, so that case is not a drop.
    always_comb begin
        sw_rel       = r_sw_prev & ~i_sw;
        grant_mask   = grant_valid ? (4'b0001 << grant_idx) : 4'b0000;
        pending_keep = pending & ~grant_mask;
        pending_next = pending_keep | sw_rel;
        drop_any     = |(sw_rel & pending_keep);
        count_next   = (count == 4'd9) ? 4'd0 : count + 4'd1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sw_prev  <= 4'b0000;
            pending    <= 4'b0000;
            last_grant <= 2'd3;
            timer      <= '0;
            count      <= 4'd0;
            o_led      <= 4'b0000;
            o_seg1     <= SEG_BLANK;
            o_seg2     <= 7'b1000000;
            o_busy     <= 1'b0;
            o_drop     <= 1'b0;
        end else begin
            r_sw_prev <= i_sw;
            pending   <= pending_next;
            o_drop    <= drop_any;
            if (grant_valid) begin
                last_grant <= grant_idx;
                o_led      <= o_led ^ grant_mask;
                o_seg1     <= seg_digit({2'b00, grant_idx} + 4'd1);
                count      <= count_next;
                o_seg2     <= seg_digit(count_next);
                timer      <= TIMER_LOAD;
                o_busy     <= 1'b1;
            end else if (state == SHOW) begin
                if (timer == '0) begin
                    o_seg1 <= SEG_BLANK;
                    o_busy <= 1'b0;
                end else begin
                    timer <= timer - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_event_scheduler.sv
// Randomized and directed bench for switch_event_scheduler against an event-level reference model.
module tb_switch_event_scheduler;

    localparam int DC = 4;

    logic       i_clk;
    logic       i_rst;
    logic [3:0] i_sw;
    logic [3:0] o_led;
    logic [6:0] o_seg1;
    logic [6:0] o_seg2;
    logic       o_busy;
    logic       o_drop;

    switch_event_scheduler #(.DISPLAY_CYCLES(DC)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_sw  (i_sw),
        .o_led (o_led),
        .o_seg1(o_seg1),
        .o_seg2(o_seg2),
        .o_busy(o_busy),
        .o_drop(o_drop)
    );

    // clock / cycle counter
    int unsigned cyc = 0;
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end
    initial forever begin
        @(posedge i_clk);
        cyc++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    // reference model: expected grants {cycle, led, seg1, seg2} and drop cycles
    logic [49:0] exp_q[$];
    logic [31:0] drop_q[$];

    logic [6:0] seg_tab[10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    bit         m_pend[4];
    int         m_last;
    logic [3:0] m_led;
    int         m_cnt;
    int         m_left;
    logic [3:0] m_prev;

    task automatic model_reset();
        for (int n = 0; n < 4; n++) m_pend[n] = 1'b0;
        m_last = 3;
        m_led  = 4'b0000;
        m_cnt  = 0;
        m_left = 0;
        m_prev = 4'b0000;
    endtask

    task automatic model_edge(input logic [3:0] sw, input logic [31:0] edge_cyc);
        int g;
        int idx;
        bit drop;
        g = -1;
        if (m_left == 0) begin
            for (int i = 0; i < 4; i++) begin
`ifdef SWITCH_EVENT_SCHEDULER_FIXED_PRIO_EN
                idx = i;
`else
                idx = (m_last + 1 + i) % 4;
`endif
                if (g < 0 && m_pend[idx]) g = idx;
            end
            if (g >= 0) begin
                m_pend[g] = 1'b0;
                m_last    = g;
                m_led[g]  = ~m_led[g];
                m_cnt     = (m_cnt + 1) % 10;
                m_left    = DC;
                exp_q.push_back({edge_cyc, m_led, seg_tab[g + 1], seg_tab[m_cnt]});
            end
        end else begin
            m_left--;
        end
        drop = 1'b0;
        for (int n = 0; n < 4; n++) begin
            if (m_prev[n] && !sw[n]) begin
                if (m_pend[n]) drop = 1'b1;
                else           m_pend[n] = 1'b1;
            end
        end
        if (drop) drop_q.push_back(edge_cyc);
        m_prev = sw;
    endtask

    // driver tasks
    task automatic step(input logic [3:0] sw);
        @(negedge i_clk);
        i_sw = sw;
        model_edge(sw, cyc + 1);
        @(posedge i_clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(i_sw);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_led"},  o_led,  4'b0000);
        check({tag, "_seg1"}, o_seg1, 7'b1111111);
        check({tag, "_seg2"}, o_seg2, 7'b1000000);
        check({tag, "_busy"}, o_busy, 1'b0);
        check({tag, "_drop"}, o_drop, 1'b0);
    endtask

    // monitor / scoreboard
    bit busy_prev;
    int busy_len;
    initial begin
        logic [49:0] e;
        logic [31:0] d;
        busy_prev = 1'b0;
        busy_len  = 0;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                busy_prev = 1'b0;
                busy_len  = 0;
            end else begin
                if (o_busy) begin
                    if (!busy_prev) begin
                        if (exp_q.size() == 0) flag("grant_unexpected");
                        else begin
                            e = exp_q.pop_front();
                            check("grant_cycle", cyc, e[49:18]);
                            check("grant_led",   o_led,  e[17:14]);
                            check("grant_seg1",  o_seg1, e[13:7]);
                            check("grant_seg2",  o_seg2, e[6:0]);
                        end
                    end
                    busy_len++;
                end else if (busy_prev) begin
                    check("window_len", busy_len, DC);
                    check("seg1_blank", o_seg1, 7'b1111111);
                    busy_len = 0;
                end
                if (o_drop) begin
                    if (drop_q.size() == 0) flag("drop_unexpected");
                    else begin
                        d = drop_q.pop_front();
                        check("drop_cycle", cyc, d);
                    end
                end
                busy_prev = o_busy;
            end
        end
    end

    // stimulus
    initial begin
        i_rst = 1'b1;
        i_sw  = 4'b0000;
        model_reset();
        #1 check_reset_outputs("rst0");
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;

        // single release of switch 3
        step(4'b0100); step(4'b0000); idle(8);

        // all four released together
        step(4'b1111); step(4'b0000); idle(24);

        // overrun on switch 2 during switch 1 window
        step(4'b0001); step(4'b0000);
        step(4'b0010); step(4'b0000);
        step(4'b0010); step(4'b0000);
        idle(16);

        // ten events on switch 4 wraps the counter
        repeat (10) begin
            step(4'b1000); step(4'b0000); idle(6);
        end

        // arbitration order with requests queued during a window
        step(4'b0001); step(4'b0000);
        step(4'b0100); step(4'b0000);
        step(4'b0010); step(4'b0000);
        step(4'b0001); step(4'b0000);
        idle(20);

        // reset in the middle of a window
        step(4'b0010); step(4'b0000); step(4'b0000); step(4'b0000);
        #2 i_rst = 1'b1;
        #1 check_reset_outputs("rst_mid");
        @(negedge i_clk);
        i_sw = 4'b0000;
        model_reset();
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        step(4'b0001); step(4'b0000); idle(8);

        // random toggling
        repeat (1500) step(i_sw ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15))));
        step(4'b0000);
        idle(30);

        check("grants_outstanding", exp_q.size(), 0);
        check("drops_outstanding", drop_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/switch_event_scheduler.md
Name: switch_event_scheduler

Overview:
Sequences release events from four debounced switches onto the board's shared LED and 7-segment resources. Release edges are latched as pending requests. A round-robin arbiter grants one event at a time. Each grant toggles that switch's LED and holds the switch number on digit 1 for a fixed display window. Digit 2 always shows a decimal event counter. The block sits between the per-switch debounce instances and the board outputs in the top level.

Parameters:
DISPLAY_CYCLES, 25000000, length of a display window in i_clk cycles (1 s at 25 MHz); legal range >= 2.
CNT_W, $clog2(DISPLAY_CYCLES), width of the window timer; derived, do not override.

Ports:
i_clk  input  1  system clock
i_rst  input  1  reset, asynchronous, active-high
i_sw  input  4  debounced switch levels; bit n = switch n+1; 1 = pressed
o_led  output  4  LED drive; bit n toggles on each grant to switch n+1
o_seg1  output  7  digit 1 segments {g,f,e,d,c,b,a}, active-low
o_seg2  output  7  digit 2 segments {g,f,e,d,c,b,a}, active-low
o_busy  output  1  1 while a display window is active
o_drop  output  1  one-cycle pulse when a release is lost

Behaviour:
- Reset (async assert, all registers): r_sw_prev=0, pending=0, last_grant=3, state=IDLE, timer=0, o_led=0, o_seg1=7'b1111111 (blank), o_seg2=digit 0 (7'b1000000), count=0, o_busy=0, o_drop=0. Reset asserted mid-window aborts the window with no residual state.
- Edge detect: registered r_sw_prev. A release is r_sw_prev[n]=1 and i_sw[n]=0 at a clock edge.
- A release sets pending[n] at that edge. If pending[n] is already 1 and not being granted that cycle, the event is dropped: pending stays 1 and o_drop=1 for one cycle. Multiple drops in one cycle give a single pulse.
- Set and clear of the same bit in one cycle: the grant clears the old request and the new release sets pending again, so the bit ends at 1 with no drop.
- FSM states:
  - IDLE: if pending!=0, grant the first set bit searching from last_grant+1 upward, wrapping 3->0. On that edge: clear pending[g], last_grant=g, toggle o_led[g], o_seg1=digit g+1, count=(count==9)?0:count+1, o_seg2=digit of new count, timer=DISPLAY_CYCLES-1, o_busy=1, state=SHOW.
  - SHOW: timer decrements each cycle. When timer==0: o_seg1=blank, o_busy=0, state=IDLE. The next grant is earliest on the following edge, so there is at least one IDLE cycle between windows.
  - Window length: o_busy is high for exactly DISPLAY_CYCLES cycles.
- Latency: release sampled at edge k -> pending at edge k. If IDLE, grant outputs are registered at edge k+1.
- Releases arriving during SHOW are queued (one per switch) and served in round-robin order after the window.
- Digit encodings (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- All outputs are registered; no combinational path from i_sw to any output.

Optional Feature:
Macro SWITCH_EVENT_SCHEDULER_FIXED_PRIO_EN.
- Defined: the arbiter uses fixed priority, lowest index first (switch 1 highest); last_grant still updates but does not affect selection.
- Undefined (default): round-robin as described above.

Test Plan:
(DISPLAY_CYCLES=4 on the bench.)
- Reset: assert i_rst mid-cycle with no clock -> immediately o_led=0000, o_seg1=1111111, o_seg2=1000000, o_busy=0.
- Single event: i_sw[2] 1->0 at edge k -> at edge k+1 o_led=0100, o_seg1=0110000 ("3"), o_seg2=1111001 ("1"). o_busy high for 4 cycles, then o_seg1 blank.
- Simultaneous releases of all four switches at edge k -> grants in order sw1,sw2,sw3,sw4 (last_grant=3 after reset). Windows start at edges k+1, k+6, k+11, k+16. Final o_led=1111, o_seg2="4".
- Overrun: release sw1, then during its window press and release sw2 twice -> second sw2 release gives o_drop=1 for one cycle. Only one sw2 grant follows; count ends at 2.
- Wrap: 10 sequential events on sw4 -> o_led[3] ends at 0, o_seg2 shows "0".
- With SWITCH_EVENT_SCHEDULER_FIXED_PRIO_EN: grant sw1, then release sw3 and sw2 during the window, and re-release sw1 -> sw1 is granted before sw2 and sw3, with sw2 before sw3.
